// File: rtl/mc_input_interface_pkg.sv
// Shared definitions for the multi-channel operation-packet input interface:
// default field widths, the highest legal mode code, drop-reason codes and
// the packed packet width.
package mc_input_interface_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_MODES  = 3;
    localparam int RES_WIDTH  = 4;
    localparam int MAX_MODE   = 5;

    // Packets are stored packed as {res, mode, data}
    localparam int PKT_WIDTH = RES_WIDTH + NUM_MODES + DATA_WIDTH;

    typedef enum logic [1:0] {
        DROP_NONE    = 2'b00,
        DROP_ILLEGAL = 2'b01,
        DROP_OVF     = 2'b10
    } drop_rsn_e;

endpackage

// File: rtl/mc_input_interface_fifo.sv
// mc_in_fifo: synchronous FIFO with a separate occupancy counter (0..DEPTH).
// The head entry is presented combinationally on rdata. A push and a pop in
// the same cycle on a full FIFO both succeed because the read side frees the
// slot the write side fills.
module mc_in_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; data array carries no reset.
    // NOTE: the memory is left unreset on purpose: an entry is never read before
    // it is written, and omitting the reset lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^AW).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/mc_input_interface.sv
// mc_input_interface: NUM_CH packet ports, each with a legality checker and a
// DEPTH-entry FIFO, merged by a round-robin arbiter into one registered
// valid/ready stream tagged with the source channel.
// Optional feature: define IN_IF_DROP_CNT_EN to add per-channel saturating
// 16-bit drop counters (drop_cnt) with a synchronous clear (drop_cnt_clr).
module mc_input_interface #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = mc_input_interface_pkg::DATA_WIDTH,
    parameter int NUM_MODES  = mc_input_interface_pkg::NUM_MODES,
    parameter int RES_WIDTH  = mc_input_interface_pkg::RES_WIDTH,
    parameter int DEPTH      = 8,
    parameter int MAX_MODE   = mc_input_interface_pkg::MAX_MODE,
    parameter int AFULL_TH   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CH-1:0]                      pkt_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]           op_pkt__data,
    input  logic [NUM_CH*NUM_MODES-1:0]            op_pkt__mode,
    input  logic [NUM_CH*RES_WIDTH-1:0]            op_pkt__res,
    output logic [NUM_CH-1:0]                      ready,
    output logic [NUM_CH-1:0]                      pkt_dropd,
    output logic [NUM_CH*2-1:0]                    drop_rsn,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [NUM_MODES-1:0]                   out_mode,
    output logic [RES_WIDTH-1:0]                   out_res,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    fifo_level
`ifdef IN_IF_DROP_CNT_EN
    ,
    input  logic                                   drop_cnt_clr,
    output logic [NUM_CH*16-1:0]                   drop_cnt
`endif
);

    import mc_input_interface_pkg::*;

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PW    = RES_WIDTH + NUM_MODES + DATA_WIDTH;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [PW-1:0]     rdata [NUM_CH];
    logic [LVL_W-1:0]  level [NUM_CH];

    logic [NUM_CH-1:0] drop_nxt;
    logic [1:0]        rsn_nxt [NUM_CH];
    logic [NUM_CH-1:0] ready_nxt;

    logic              found;
    logic              load;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;

    // Per-channel FIFOs
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mc_in_fifo #(
            .WIDTH (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata ({op_pkt__res[c*RES_WIDTH +: RES_WIDTH],
                     op_pkt__mode[c*NUM_MODES +: NUM_MODES],
                     op_pkt__data[c*DATA_WIDTH +: DATA_WIDTH]}),
            .rdata (rdata[c]),
            .level (level[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
        assign fifo_level[c*LVL_W +: LVL_W] = level[c];
    end

    // Round-robin grant: first non-empty channel at or after rr_ptr, wrapping.
    // NOTE: combinational blocks use blocking '=' with a default for every
    // output first, so no latch is inferred on paths that skip an assignment.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
        load = found && (!out_valid || out_ready);
        pop  = '0;
        if (load) pop[grant] = 1'b1;
    end

    // Legality check, push/drop decision and next-cycle ready per channel.
    always_comb begin
        logic [NUM_MODES-1:0] mode;
        logic                 legal;
        int                   lv;
        for (int c = 0; c < NUM_CH; c++) begin
            mode  = op_pkt__mode[c*NUM_MODES +: NUM_MODES];
            legal = (mode != '0) && (int'(mode) <= MAX_MODE);
            // A pop at the same edge frees a slot, so a full FIFO still accepts.
            push[c]     = pkt_valid[c] && legal && (!full[c] || pop[c]);
            drop_nxt[c] = pkt_valid[c] && !push[c];
            if (!drop_nxt[c])  rsn_nxt[c] = DROP_NONE;
            else if (!legal)   rsn_nxt[c] = DROP_ILLEGAL;
            else               rsn_nxt[c] = DROP_OVF;
            lv           = int'(level[c]) + int'(push[c]) - int'(pop[c]);
            ready_nxt[c] = (DEPTH - lv) > AFULL_TH;
        end
    end

    // Registered drop pulse, drop reason and almost-full ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_dropd <= '0;
            drop_rsn  <= '0;
            ready     <= '1;
        end else begin
            pkt_dropd <= drop_nxt;
            ready     <= ready_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                drop_rsn[c*2 +: 2] <= rsn_nxt[c];
            end
        end
    end

    // Output register and round-robin pointer; fields hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            out_res   <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid                      <= 1'b1;
            {out_res, out_mode, out_data}  <= rdata[grant];
            out_ch                         <= grant;
            rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef IN_IF_DROP_CNT_EN
    // Saturating drop counters; a clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (drop_cnt_clr) begin
                    drop_cnt[c*16 +: 16] <= '0;
                end else if (pkt_dropd[c] && (drop_cnt[c*16 +: 16] != 16'hFFFF)) begin
                    drop_cnt[c*16 +: 16] <= drop_cnt[c*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    // Drop counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mc_input_interface.sv
// Testbench for mc_input_interface (default parameters). Stimulus pushes the
// expected output packets into a scoreboard queue; a monitor process pops and
// compares on every accepted output beat and checks stability while stalled.
module tb_mc_input_interface;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int MW     = 3;
    localparam int RW     = 4;
    localparam int LW     = 4;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        logic [MW-1:0] mode;
        logic [RW-1:0] res;
    } pkt_t;

    logic                   clk;
    logic                   rst;
    logic [NUM_CH-1:0]      pkt_valid;
    logic [NUM_CH*DW-1:0]   op_data;
    logic [NUM_CH*MW-1:0]   op_mode;
    logic [NUM_CH*RW-1:0]   op_res;
    logic [NUM_CH-1:0]      ready;
    logic [NUM_CH-1:0]      pkt_dropd;
    logic [NUM_CH*2-1:0]    drop_rsn;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [MW-1:0]          out_mode;
    logic [RW-1:0]          out_res;
    logic [1:0]             out_ch;
    logic [NUM_CH*LW-1:0]   fifo_level;
`ifdef IN_IF_DROP_CNT_EN
    logic                   drop_cnt_clr;
    logic [NUM_CH*16-1:0]   drop_cnt;
`endif

    logic [DW-1:0] d_in [NUM_CH];
    logic [MW-1:0] m_in [NUM_CH];
    logic [RW-1:0] r_in [NUM_CH];

    pkt_t exp_q [$];
    int   vectors;
    int   miscompares;

    mc_input_interface dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .op_pkt__data (op_data),
        .op_pkt__mode (op_mode),
        .op_pkt__res  (op_res),
        .ready        (ready),
        .pkt_dropd    (pkt_dropd),
        .drop_rsn     (drop_rsn),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .out_res      (out_res),
        .out_ch       (out_ch),
        .fifo_level   (fifo_level)
`ifdef IN_IF_DROP_CNT_EN
        ,
        .drop_cnt_clr (drop_cnt_clr),
        .drop_cnt     (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        op_data = '0;
        op_mode = '0;
        op_res  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            op_data[c*DW +: DW] = d_in[c];
            op_mode[c*MW +: MW] = m_in[c];
            op_res[c*RW +: RW]  = r_in[c];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [MW-1:0] m);
        return (m != 0) && (m <= 5);
    endfunction

    // Present a packet on channel c for the next edge; legal ones are expected out.
    task automatic set_pkt(input int c, input logic [DW-1:0] d, input logic [MW-1:0] m,
                           input logic [RW-1:0] r, input bit expect_out);
        pkt_t p;
        pkt_valid[c] = 1'b1;
        d_in[c] = d;
        m_in[c] = m;
        r_in[c] = r;
        if (expect_out && is_legal(m)) begin
            p = '{ch: 2'(c), data: d, mode: m, res: r};
            exp_q.push_back(p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pkt_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step();
        step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare each accepted output beat against the scoreboard and
    // require all fields to hold while out_valid is stalled.
    initial begin
        pkt_t prev;
        pkt_t got;
        pkt_t exp;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = '{ch: out_ch, data: out_data, mode: out_mode, res: out_res};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {out_valid, 63'(got)}, {1'b1, 63'(prev)});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_pkt", 64'(got), 64'(exp));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev       = got;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        pkt_valid   = '0;
        out_ready   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            d_in[c] = '0;
            m_in[c] = '0;
            r_in[c] = '0;
        end
`ifdef IN_IF_DROP_CNT_EN
        drop_cnt_clr = 1'b0;
`endif
        #12;
        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(ready), 64'hF);
        check("rst_dropd", 64'({pkt_dropd, drop_rsn}), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_fields", 64'({out_ch, out_data, out_mode, out_res}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Legal packet on ch0, two-edge latency
        out_ready = 1'b1;
        set_pkt(0, 32'hDEADBEEF, 3'd3, 4'h5, 1'b1);
        step();
        check("legal_level1", 64'(fifo_level[3:0]), 64'd1);
        check("legal_not_yet", 64'(out_valid), 64'd0);
        step();
        check("legal_valid", 64'(out_valid), 64'd1);
        check("legal_level0", 64'(fifo_level[3:0]), 64'd0);
        step();

        // Illegal packets on ch1: mode 0 then mode 6
        set_pkt(1, 32'h1111_0000, 3'd0, 4'h1, 1'b1);
        step();
        check("illegal0_drop", 64'({pkt_dropd, drop_rsn}), {56'd0, 4'b0010, 8'b0000_0100});
        set_pkt(1, 32'h1111_0006, 3'd6, 4'h2, 1'b1);
        step();
        check("illegal6_drop", 64'({pkt_dropd, drop_rsn}), {56'd0, 4'b0010, 8'b0000_0100});
        step();
        check("drop_pulse_end", 64'({pkt_dropd, drop_rsn}), 64'd0);
        check("illegal_no_out", 64'({out_valid, fifo_level}), 64'd0);
`ifdef IN_IF_DROP_CNT_EN
        check("cnt_after_illegal", 64'(drop_cnt[31:16]), 64'd2);
        set_pkt(1, 32'h0, 3'd7, 4'h0, 1'b1);
        step();
        drop_cnt_clr = 1'b1;
        step();
        drop_cnt_clr = 1'b0;
        check("cnt_clr_wins", 64'(drop_cnt), 64'd0);
        step();
        check("cnt_clr_stays", 64'(drop_cnt), 64'd0);
`endif

        // Overflow on ch2 with the output register already stalled by a ch0 packet
        do_reset();
        out_ready = 1'b0;
        set_pkt(0, 32'hA0A0_0001, 3'd1, 4'h1, 1'b1);
        step();
        step();
        check("ovf_primed", 64'(out_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            set_pkt(2, 32'hC200_0000 + k, 3'd2, 4'(k), k < 8);
            step();
            check("ovf_level", 64'(fifo_level[11:8]), (k < 8) ? 64'(k + 1) : 64'd8);
            check("ovf_ready", 64'(ready[2]), (k < 5) ? 64'd1 : 64'd0);
            check("ovf_drop", 64'({pkt_dropd[2], drop_rsn[5:4]}), (k < 8) ? 64'd0 : 64'b110);
        end
        out_ready = 1'b1;
        drain("ovf_drain", 20);
        check("ovf_ready_back", 64'(ready), 64'hF);

        // Round robin: four channels, two packets each
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_pkt(c, 32'h0000_0100 * (c + 1) + r, 3'(c + 1), 4'(r), 1'b1);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_no_bubble", 64'(out_valid), 64'd1);
        end
        step();
        check("rr_all_out", 64'(exp_q.size()), 64'd0);

        // Backpressure: out_ready toggling 1,0,1,0
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pkt(3, 32'hB300_0000 + k, 3'd5, 4'(k + 8), 1'b1);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b1;
        drain("bp_drain", 10);

        // Simultaneous push and pop on a full FIFO
        do_reset();
        out_ready = 1'b0;
        set_pkt(1, 32'hF100_0000, 3'd4, 4'hA, 1'b1);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            set_pkt(1, 32'hF100_0010 + k, 3'd1, 4'(k), 1'b1);
            step();
        end
        check("full_level", 64'(fifo_level[7:4]), 64'd8);
        check("full_ready", 64'(ready[1]), 64'd0);
        out_ready = 1'b1;
        set_pkt(1, 32'hF100_00FF, 3'd2, 4'hF, 1'b1);
        step();
        check("pushpop_no_drop", 64'(pkt_dropd), 64'd0);
        check("pushpop_level", 64'(fifo_level[7:4]), 64'd8);
        drain("pushpop_drain", 20);

        // Mid-stream reset with packets buffered and a drop recorded
        out_ready = 1'b0;
        set_pkt(0, 32'h5555_0000, 3'd1, 4'h0, 1'b0);
        set_pkt(1, 32'h5555_0001, 3'd2, 4'h1, 1'b0);
        set_pkt(2, 32'h5555_0002, 3'd7, 4'h2, 1'b0);
        step();
        set_pkt(0, 32'h5555_0003, 3'd3, 4'h3, 1'b0);
        step();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #2;
        check("mid_rst_out", 64'({out_valid, out_ch, out_data, out_mode, out_res}), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'hF);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_drop", 64'({pkt_dropd, drop_rsn}), 64'd0);
`ifdef IN_IF_DROP_CNT_EN
        check("mid_rst_cnt", 64'(drop_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("no_stale", 64'({out_valid, fifo_level}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_input_interface.md
Name: mc_input_interface

Overview:
Parametrised multi-channel successor to the single-channel operation-packet input interface.
- NUM_CH independent packet ports, each with a legality checker and a DEPTH-entry FIFO.
- A round-robin arbiter merges the FIFOs into one registered valid/ready output stream toward the op decoder, tagged with source channel.
- Adds per-channel drop reasons and almost-full backpressure, which the single-channel block lacks.

Parameters:
NUM_CH, 4, number of input channels (1..8)
DATA_WIDTH, 32, operand data width
NUM_MODES, 3, mode field width
RES_WIDTH, 4, result-select field width
DEPTH, 8, FIFO entries per channel (power of 2, >=2)
MAX_MODE, 5, highest legal mode code
AFULL_TH, 2, ready deasserts when free entries <= AFULL_TH

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pkt_valid  in  NUM_CH  per-channel packet strobe
op_pkt__data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
op_pkt__mode  in  NUM_CH*NUM_MODES  per-channel mode
op_pkt__res  in  NUM_CH*RES_WIDTH  per-channel result select
ready  out  NUM_CH  per-channel ready (almost-full based)
pkt_dropd  out  NUM_CH  one-cycle drop pulse
drop_rsn  out  NUM_CH*2  drop reason, valid with pkt_dropd
out_valid  out  1  output packet valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  packet data
out_mode  out  NUM_MODES  packet mode
out_res  out  RES_WIDTH  packet result select
out_ch  out  $clog2(NUM_CH) (min 1)  source channel
fifo_level  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-high.
- Reset clears all FIFO pointers, levels, and the arbiter pointer (to channel 0). Reset drives out_valid=0, out_data/mode/res/out_ch=0, pkt_dropd=0, drop_rsn=0, and ready=all-ones.
- Reset mid-operation discards all buffered and in-flight packets. Nothing is replayed.

Checker (per channel, combinational on input):
- A packet is legal iff mode!=0 and mode<=MAX_MODE.
- On pkt_valid:
  - Legal and FIFO not full: push at this edge.
  - Illegal: drop with drop_rsn=2'b01.
  - Legal but FIFO full: drop with drop_rsn=2'b10 (overflow).
- pkt_dropd and drop_rsn are registered and assert the cycle after pkt_valid, for exactly 1 cycle.
- drop_rsn is 2'b00 whenever pkt_dropd=0.

Ready:
- ready[c] = (DEPTH - level[c]) > AFULL_TH, registered from the post-edge level.
- Senders that ignore ready may still push until the FIFO is actually full.

FIFO:
- Width DATA_WIDTH+NUM_MODES+RES_WIDTH, packed {res,mode,data}.
- Pointers wrap modulo DEPTH. The level counter is separate and ranges 0..DEPTH.
- Simultaneous push and pop on a full FIFO:
  - Pop first, then push succeeds.
  - Level stays DEPTH.
  - No overflow drop.
- Pop on empty never occurs; the arbiter only grants non-empty FIFOs.

Arbiter/output:
- Output register loads when (!out_valid || out_ready) and at least one FIFO is non-empty.
- Grant goes to the first non-empty channel at or after rr_ptr, wrapping. The granted FIFO pops at that same edge.
- rr_ptr then becomes grant+1 mod NUM_CH.
- Full throughput: one packet per cycle with out_ready held high.
- Latency: pkt_valid at edge N → out_valid at edge N+2 when the output is idle.
- While out_valid=1 && out_ready=0, all output fields are held stable.

Optional Feature:
Macro IN_IF_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [NUM_CH*16].
  - Per-channel 16-bit counters increment on each pkt_dropd and saturate at 16'hFFFF.
  - Adds input drop_cnt_clr, a 1-cycle pulse that zeroes all counters.
  - Clear wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package/header (extends param.vh):
  - DATA_WIDTH, NUM_MODES, RES_WIDTH.
  - MAX_MODE.
  - drop-reason codes DROP_NONE=0, DROP_ILLEGAL=1, DROP_OVF=2.
  - Packed packet-width localparam.
- One natural sub-module: mc_in_fifo, a parametrised sync FIFO (WIDTH, DEPTH) with level, full, and empty outputs, instanced per channel via generate.
- Checker and arbiter stay inline.

Test Plan:
- Legal packet: ch0 pkt_valid with mode=3, data=32'hDEADBEEF, res=4'h5, out_ready=1 → out_valid at +2 cycles with out_ch=0 and matching fields; fifo_level[0] goes 1 then 0.
- Illegal packet: ch1 mode=0, then mode=6 → pkt_dropd[1] pulses on the next cycle with drop_rsn=01; no output.
- Overflow: DEPTH=8, out_ready=0, 10 legal pushes on ch2 →
  - ready[2] falls after level reaches 6;
  - the 9th and 10th pushes drop with rsn=10;
  - after out_ready=1, exactly 8 packets emerge in order.
- Round-robin: all 4 channels each hold 2 packets, out_ready=1 → out_ch sequence 0,1,2,3,0,1,2,3, with no bubbles.
- Backpressure and full-FIFO push/pop:
  - out_ready toggles 1010 → output fields stable while stalled, no loss or duplication;
  - simultaneous push and pop on a full FIFO → no drop.
- Mid-stream reset: rst asserted with packets buffered → all outputs return to reset values immediately; after release, no stale packets appear. With IN_IF_DROP_CNT_EN, counters reach 0 and drop_cnt_clr is checked against a coincident drop.
